i2c_cmd_seq: RTL and testbench

//  Transaction sequencer sitting directly upstream of i2c_contrl.
//  - Accepts one register-level I2C command (device address, register address, R/W, 1..MAX_BYTES data bytes).
//  - Breaks it into per-byte i2c_wdata/i2c_control/cfg_trigger requests.
//  - Paces each byte on i2c_status busy, collects read bytes from i2c_rdata and returns a single response.
//  - i2c_control encoding: [0] START, [1] STOP, [2] WRITE, [3] READ, [4] NACK after read byte, [7:5] 0.

---
 rtl/i2c_cmd_seq.sv | 253 +++++++++++++++++++++++++
 tb/tb_i2c_cmd_seq.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_cmd_seq.sv
// ----------------------------------------------------------------------------
// i2c_cmd_seq
// Transaction sequencer placed directly in front of i2c_contrl. It takes one
// register-level I2C command, splits it into per-byte wdata/control/trigger
// requests, paces each byte on the controller busy flag, gathers read bytes
// and returns a single response.
//
// Handshakes:
//   cmd_valid/cmd_ready : a command is accepted on a clock edge where both are
//                         high. cmd_ready is high only in IDLE. A cmd_valid seen
//                         outside IDLE is ignored, not queued.
//   rsp_valid           : one-cycle strobe with no back-pressure. rsp_ack_err,
//                         rsp_timeout and rsp_rdata hold their values from the
//                         strobe cycle until the next accept.
//   cfg_trigger         : one-cycle pulse that starts a byte in i2c_contrl.
//                         i2c_wdata/i2c_control are already stable during it.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_dev_addr          7-bit target address
//   cmd_reg_addr          target register address
//   cmd_rnw               1 = read, 0 = write
//   cmd_len               data byte count (clamped to MAX_BYTES; read 0 -> 1)
//   cmd_wdata             write bytes, byte0 in [7:0] is sent first
//   rsp_valid             one-cycle response strobe
//   rsp_ack_err           NACK seen during the command
//   rsp_timeout           a byte exceeded TIMEOUT_CYC
//   rsp_rdata             read bytes, byte k at [8k+7:8k], unread bytes 0
//   i2c_wdata/i2c_control byte and control to i2c_contrl
//                         control: [0] START [1] STOP [2] WRITE [3] READ [4] NACK
//   cfg_trigger           start-byte pulse
//   i2c_status            [0] busy, [1] ack_err
//   i2c_rdata             last byte read by i2c_contrl
//   o_dbg_state           current FSM state, for observation only
// ----------------------------------------------------------------------------
module i2c_cmd_seq #(
    parameter int MAX_BYTES   = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [6:0]             cmd_dev_addr,
    input  logic [7:0]             cmd_reg_addr,
    input  logic                   cmd_rnw,
    input  logic [3:0]             cmd_len,
    input  logic [8*MAX_BYTES-1:0] cmd_wdata,
    output logic                   rsp_valid,
    output logic                   rsp_ack_err,
    output logic                   rsp_timeout,
    output logic [8*MAX_BYTES-1:0] rsp_rdata,
    output logic [7:0]             i2c_wdata,
    output logic [7:0]             i2c_control,
    output logic                   cfg_trigger,
    input  logic [7:0]             i2c_status,
    input  logic [7:0]             i2c_rdata,
    output logic [2:0]             o_dbg_state
);
    localparam int          DW    = 8 * MAX_BYTES;
    localparam logic [3:0]  L_MAX = 4'(MAX_BYTES);
    localparam logic [15:0] L_TMO = 16'(TIMEOUT_CYC);

    localparam logic [7:0] C_START = 8'h01;
    localparam logic [7:0] C_STOP  = 8'h02;
    localparam logic [7:0] C_WRITE = 8'h04;
    localparam logic [7:0] C_READ  = 8'h08;
    localparam logic [7:0] C_NACK  = 8'h10;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_TRIG, S_WAIT_HI, S_WAIT_LO, S_NEXT, S_ABORT, S_RESP
    } state_t;

    state_t          r_state, w_next;
    logic            r_cmd_ready;
    logic [6:0]      r_dev;
    logic [7:0]      r_reg;
    logic            r_rnw;
    logic [3:0]      r_len;
    logic [DW-1:0]   r_wdata;
    logic [3:0]      r_idx;
    logic            r_abort;
    logic [15:0]     r_cnt;
    logic            r_ack_err;
    logic            r_timeout;
    logic [DW-1:0]   r_rdata;
    logic [7:0]      r_i2c_wdata;
    logic [7:0]      r_i2c_control;

    logic            w_accept, w_busy, w_nack, w_tmo, w_last;
    logic [15:0]     w_cnt_inc;
    logic [3:0]      w_len_eff;
    logic [3:0]      w_data_idx;
    logic [7:0]      w_byte_data, w_byte_ctrl;
    logic            w_unused_status;

    assign w_accept        = cmd_valid & r_cmd_ready;
    assign w_busy          = i2c_status[0];
    assign w_nack          = i2c_status[1];
    assign w_unused_status = ^i2c_status[7:2];
    assign w_cnt_inc       = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
    assign w_tmo           = (w_cnt_inc >= L_TMO);

    always_comb begin
        w_len_eff = cmd_len;
        if (cmd_len > L_MAX)
            w_len_eff = L_MAX;
        if (cmd_rnw && (cmd_len == 4'd0))
            w_len_eff = 4'd1;
    end

    // Byte list. Writes: addr, reg, data...; reads: addr, reg, addr|1, data...
    // w_data_idx is the data-byte number for the current index in both cases.
    always_comb begin
        w_byte_data = 8'h00;
        w_byte_ctrl = 8'h00;
        w_data_idx  = r_idx - (r_rnw ? 4'd3 : 4'd2);
        w_last      = r_rnw ? (r_idx == r_len + 4'd2) : (r_idx == r_len + 4'd1);
        case (r_idx)
            4'd0: begin
                w_byte_data = {r_dev, 1'b0};
                w_byte_ctrl = C_START | C_WRITE;
            end
            4'd1: begin
                w_byte_data = r_reg;
                w_byte_ctrl = (w_last && !r_rnw) ? (C_WRITE | C_STOP) : C_WRITE;
            end
            default: begin
                if (r_rnw && (r_idx == 4'd2)) begin
                    w_byte_data = {r_dev, 1'b1};
                    w_byte_ctrl = C_START | C_WRITE;
                end else if (r_rnw) begin
                    w_byte_ctrl = w_last ? (C_READ | C_NACK | C_STOP) : C_READ;
                end else begin
                    for (int k = 0; k < MAX_BYTES; k++)
                        if (w_data_idx == 4'(k))
                            w_byte_data = r_wdata[8*k +: 8];
                    w_byte_ctrl = w_last ? (C_WRITE | C_STOP) : C_WRITE;
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic. LOAD and ABORT hold off the trigger while busy so a
    // trigger never lands on a controller that is still working.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_accept) w_next = S_LOAD;
            S_LOAD:    if (!w_busy) w_next = S_TRIG;
            S_TRIG:    w_next = S_WAIT_HI;
            S_WAIT_HI: if (w_tmo) w_next = S_RESP;
                       else if (w_busy) w_next = S_WAIT_LO;
            S_WAIT_LO: if (w_tmo) w_next = S_RESP;
                       else if (!w_busy) w_next = S_NEXT;
            S_NEXT:    if (r_abort) w_next = S_RESP;
                       else if (w_nack) w_next = S_ABORT;
                       else if (w_last) w_next = S_RESP;
                       else w_next = S_LOAD;
            S_ABORT:   if (!w_busy) w_next = S_TRIG;
            S_RESP:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cmd_ready   <= 1'b0;
            r_dev         <= 7'd0;
            r_reg         <= 8'd0;
            r_rnw         <= 1'b0;
            r_len         <= 4'd0;
            r_wdata       <= '0;
            r_idx         <= 4'd0;
            r_abort       <= 1'b0;
            r_cnt         <= 16'd0;
            r_ack_err     <= 1'b0;
            r_timeout     <= 1'b0;
            r_rdata       <= '0;
            r_i2c_wdata   <= 8'd0;
            r_i2c_control <= 8'd0;
        end else begin
            // Ready only while IDLE persists; drops the cycle after an accept
            // and rises one cycle after re-entering IDLE.
            r_cmd_ready <= (r_state == S_IDLE) && (w_next == S_IDLE);
            if (w_accept) begin
                r_dev     <= cmd_dev_addr;
                r_reg     <= cmd_reg_addr;
                r_rnw     <= cmd_rnw;
                r_len     <= w_len_eff;
                r_wdata   <= cmd_wdata;
                r_idx     <= 4'd0;
                r_abort   <= 1'b0;
                r_ack_err <= 1'b0;
                r_timeout <= 1'b0;
                r_rdata   <= '0;
            end
            case (r_state)
                S_LOAD: begin
                    r_i2c_wdata   <= w_byte_data;
                    r_i2c_control <= w_byte_ctrl;
                end
                S_ABORT: begin
                    r_i2c_wdata   <= 8'h00;
                    r_i2c_control <= C_STOP;
                    r_abort       <= 1'b1;
                end
                // Counter value equals cycles elapsed since the trigger.
                S_TRIG: r_cnt <= 16'd1;
                S_WAIT_HI, S_WAIT_LO: begin
                    r_cnt <= w_cnt_inc;
                    if (w_tmo)
                        r_timeout <= 1'b1;
                end
                S_NEXT: begin
                    r_idx <= r_idx + 4'd1;
                    if (!r_abort && r_i2c_control[3]) begin
                        for (int k = 0; k < MAX_BYTES; k++)
                            if (w_data_idx == 4'(k))
                                r_rdata[8*k +: 8] <= i2c_rdata;
                    end
                    if (!r_abort && w_nack)
                        r_ack_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs
    always_comb begin
        cmd_ready   = r_cmd_ready;
        rsp_valid   = (r_state == S_RESP);
        rsp_ack_err = r_ack_err;
        rsp_timeout = r_timeout;
        rsp_rdata   = r_rdata;
        i2c_wdata   = r_i2c_wdata;
        i2c_control = r_i2c_control;
        cfg_trigger = (r_state == S_TRIG);
        o_dbg_state = r_state;
    end

endmodule

// File: tb/tb_i2c_cmd_seq.sv
// ----------------------------------------------------------------------------
// tb_i2c_cmd_seq
// Directed bench for i2c_cmd_seq. A behavioural stand-in for i2c_contrl raises
// busy two cycles after each trigger, holds it a random 1..4 cycles, then
// reports ack_err/rdata. Every trigger is checked against a queue of expected
// {wdata, control} pairs filled by the directed steps.
// ----------------------------------------------------------------------------
module tb_i2c_cmd_seq;
    localparam int MB  = 4;
    localparam int DW  = 8 * MB;
    localparam int TMO = 100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [6:0]    cmd_dev_addr = 7'd0;
    logic [7:0]    cmd_reg_addr = 8'd0;
    logic          cmd_rnw = 1'b0;
    logic [3:0]    cmd_len = 4'd0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid, rsp_ack_err, rsp_timeout;
    logic [DW-1:0] rsp_rdata;
    logic [7:0]    i2c_wdata, i2c_control;
    logic          cfg_trigger;
    logic [7:0]    i2c_status;
    logic [7:0]    i2c_rdata;
    logic [2:0]    dbg_state;

    // Controller model state
    logic          m_busy = 1'b0;
    logic          m_ack = 1'b0;
    logic [7:0]    m_rdata = 8'd0;
    logic          m_hang = 1'b0;
    int            m_nack_at = -1;
    int            m_byte_no = 0;
    int            m_phase = 0;
    int            m_cnt = 0;
    logic          m_is_read = 1'b0;
    logic          m_nack_this = 1'b0;
    logic          m_prev_trig = 1'b0;
    int            m_trig_cyc = 0;
    logic [7:0]    m_rd_q[$];

    logic [15:0]   exp_q[$];
    int            n_chk = 0;
    int            n_pass = 0;
    int            n_fail = 0;
    int            n_rsp = 0;
    int            cyc = 0;

    assign i2c_status = {6'b0, m_ack, m_busy};
    assign i2c_rdata  = m_rdata;

    i2c_cmd_seq #(.MAX_BYTES(MB), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dev_addr(cmd_dev_addr), .cmd_reg_addr(cmd_reg_addr),
        .cmd_rnw(cmd_rnw), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ack_err(rsp_ack_err),
        .rsp_timeout(rsp_timeout), .rsp_rdata(rsp_rdata),
        .i2c_wdata(i2c_wdata), .i2c_control(i2c_control),
        .cfg_trigger(cfg_trigger), .i2c_status(i2c_status),
        .i2c_rdata(i2c_rdata), .o_dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [7:0] c);
        exp_q.push_back({d, c});
    endtask

    // ---------------- controller model + trigger scoreboard ----------------
    always @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_busy = 1'b0; m_ack = 1'b0; m_phase = 0; m_cnt = 0;
            m_prev_trig = 1'b0; m_byte_no = 0;
        end else begin
            if (cmd_ready)
                m_byte_no = 0;
            if (cfg_trigger) begin
                chk("trig_width", m_prev_trig, 1'b0);
                chk("trig_busy", m_busy, 1'b0);
                chk("trig_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0)
                    chk($sformatf("byte%0d", m_byte_no), {i2c_wdata, i2c_control}, exp_q.pop_front());
                m_is_read   = i2c_control[3];
                m_nack_this = (m_byte_no == m_nack_at);
                m_byte_no++;
                m_ack       = 1'b0;
                m_trig_cyc  = cyc;
                if (!m_hang) begin m_phase = 1; m_cnt = 2; end
            end else if (m_phase == 1) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b1; m_phase = 2; m_cnt = $urandom_range(1, 4);
                end
            end else if (m_phase == 2) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_busy = 1'b0; m_ack = m_nack_this; m_phase = 0;
                    if (m_is_read && m_rd_q.size() != 0)
                        m_rdata = m_rd_q.pop_front();
                end
            end
            m_prev_trig = cfg_trigger;
        end
    end

    always @(negedge clk) if (rsp_valid) n_rsp++;

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [6:0] dev, input logic [7:0] rg, input logic rnw,
                            input logic [3:0] len, input logic [DW-1:0] wd);
        int n = 0;
        while (!cmd_ready && n < 1000) begin @(negedge clk); n++; end
        chk("cmd_ready_wait", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_dev_addr = dev; cmd_reg_addr = rg;
        cmd_rnw = rnw; cmd_len = len; cmd_wdata = wd;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("cmd_ready_after_accept", cmd_ready, 1'b0);
    endtask

    task automatic wait_rsp(input string tag, input logic ack, input logic tmo,
                            input logic [DW-1:0] rd, output int at_cyc);
        int n = 0;
        while (!rsp_valid && n < 2000) begin @(negedge clk); n++; end
        at_cyc = cyc;
        chk({tag, "_rsp_seen"}, rsp_valid, 1'b1);
        chk({tag, "_ack_err"}, rsp_ack_err, ack);
        chk({tag, "_timeout"}, rsp_timeout, tmo);
        chk({tag, "_rdata"}, rsp_rdata, rd);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        @(negedge clk);
        chk({tag, "_rsp_pulse"}, rsp_valid, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int t;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_outputs", {rsp_valid, rsp_ack_err, rsp_timeout, cfg_trigger, i2c_wdata, i2c_control}, 0);
        chk("rst_state", dbg_state, 3'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", cmd_ready, 1'b1);

        // 1: write len 2
        push(8'hA0, 8'h05); push(8'h10, 8'h04); push(8'hEF, 8'h04); push(8'hBE, 8'h06);
        send_cmd(7'h50, 8'h10, 1'b0, 4'd2, 32'h0000BEEF);
        wait_rsp("wr2", 1'b0, 1'b0, 32'h0, t);

        // 2: read len 3; cmd_valid held during the transaction must be ignored
        m_rd_q = '{8'h11, 8'h22, 8'h33};
        push(8'hA0, 8'h05); push(8'h20, 8'h04); push(8'hA1, 8'h05);
        push(8'h00, 8'h08); push(8'h00, 8'h08); push(8'h00, 8'h1A);
        send_cmd(7'h50, 8'h20, 1'b1, 4'd3, 32'h0);
        cmd_valid = 1'b1; cmd_dev_addr = 7'h33;
        repeat (6) @(negedge clk);
        cmd_valid = 1'b0;
        wait_rsp("rd3", 1'b0, 1'b0, 32'h00332211, t);

        // 3: NACK on the address byte -> STOP-only byte, ack_err
        m_nack_at = 0;
        push(8'hA0, 8'h05); push(8'h00, 8'h02);
        send_cmd(7'h50, 8'h11, 1'b0, 4'd2, 32'h00005566);
        wait_rsp("nack", 1'b1, 1'b0, 32'h0, t);
        m_nack_at = -1;

        // 4: busy never rises -> timeout 100 cycles after the trigger
        m_hang = 1'b1;
        push(8'hA0, 8'h05);
        send_cmd(7'h50, 8'h12, 1'b0, 4'd1, 32'h000000AB);
        wait_rsp("tmo", 1'b0, 1'b1, 32'h0, t);
        chk("tmo_latency", t - m_trig_cyc, TMO);
        chk("tmo_ready_plus1", cmd_ready, 1'b0);
        @(negedge clk);
        chk("tmo_ready_plus2", cmd_ready, 1'b1);
        m_hang = 1'b0;

        // 5a: write len 0 -> register byte carries STOP
        push(8'hA0, 8'h05); push(8'h13, 8'h06);
        send_cmd(7'h50, 8'h13, 1'b0, 4'd0, 32'h0);
        wait_rsp("wr0", 1'b0, 1'b0, 32'h0, t);

        // 5b: write len 9 -> clamped to 4 data bytes
        push(8'hA0, 8'h05); push(8'h14, 8'h04);
        push(8'h11, 8'h04); push(8'h22, 8'h04); push(8'h33, 8'h04); push(8'h44, 8'h06);
        send_cmd(7'h50, 8'h14, 1'b0, 4'd9, 32'h44332211);
        wait_rsp("wr9", 1'b0, 1'b0, 32'h0, t);

        // 6: reset during WAIT_LO of the first read byte
        m_rd_q = '{8'h77, 8'h88};
        push(8'hA0, 8'h05); push(8'h30, 8'h04); push(8'hA1, 8'h05);
        push(8'h00, 8'h08); push(8'h00, 8'h1A);
        send_cmd(7'h50, 8'h30, 1'b1, 4'd2, 32'h0);
        n = 0;
        while (!(m_byte_no == 4 && m_busy) && n < 500) begin @(negedge clk); n++; end
        chk("rst6_reached_wait_lo", m_byte_no == 4 && m_busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst6_ready", cmd_ready, 1'b0);
        chk("rst6_i2c", {cfg_trigger, i2c_wdata, i2c_control}, 0);
        chk("rst6_rsp", {rsp_valid, rsp_ack_err, rsp_timeout, rsp_rdata}, 0);
        exp_q.delete();
        m_rd_q.delete();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        m_rd_q.push_back(8'h5A);
        push(8'hA0, 8'h05); push(8'h40, 8'h04); push(8'hA1, 8'h05); push(8'h00, 8'h1A);
        send_cmd(7'h50, 8'h40, 1'b1, 4'd0, 32'h0);
        wait_rsp("rd_after_rst", 1'b0, 1'b0, 32'h0000005A, t);

        repeat (5) @(negedge clk);
        chk("rsp_count", n_rsp, 7);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
